dbf_weight_sched: RTL and testbench

// Per-channel weight scheduler in front of the DBF complex-multiply cell. Holds a

---
 rtl/dbf_weight_sched.sv | 119 +++++++++++
 tb/tb_dbf_weight_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbf_weight_sched.sv
// Per-channel complex weight scheduler feeding the DBF multiply cell.
// Pairs each interleaved I/Q sample with its {beam,ch} weight, 1-cycle latency.
module dbf_weight_sched #(
    parameter int N_CH   = 8,
    parameter int N_BEAM = 4,
    parameter int DW     = 16,
    localparam int CW    = $clog2(N_CH),
    localparam int BW    = (N_BEAM > 1) ? $clog2(N_BEAM) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [BW-1:0] wr_beam,
    input  logic [CW-1:0] wr_ch,
    input  logic [DW-1:0] wr_real,
    input  logic [DW-1:0] wr_imag,
    input  logic [BW-1:0] beam_sel,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_I,
    input  logic [DW-1:0] in_Q,
    output logic          data_in_valid,
    output logic [DW-1:0] dataI,
    output logic [DW-1:0] dataQ,
    output logic [DW-1:0] ph_real,
    output logic [DW-1:0] ph_image,
    output logic [CW-1:0] ch_idx,
    output logic [BW-1:0] beam_act,
    output logic          frame_done,
    output logic          frame_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int         DEPTH = 1 << (BW + CW);

    logic [0:0]       state;
    logic [CW-1:0]    ch_cnt;
    logic [7:0]       gap_cnt;
    logic [2*DW-1:0]  mem [DEPTH];

    logic             sof_hit;
    logic             emit;
    logic             last;
    logic             resync;
    logic             timeout;
    logic [CW-1:0]    ch_nxt;
    logic [BW-1:0]    beam_nxt;
    logic [BW+CW-1:0] rd_addr;
    logic [BW+CW-1:0] wr_addr;

    always_comb begin
        sof_hit  = in_valid & in_sof;
        emit     = sof_hit | (in_valid & (state == RUN));
        ch_nxt   = sof_hit ? '0 : ch_cnt;
        beam_nxt = sof_hit ? beam_sel : beam_act;
        last     = emit & (ch_nxt == CW'(N_CH - 1));
        resync   = (state == RUN) & sof_hit;
        timeout  = (state == RUN) & ~in_valid & (gap_cnt == 8'hff);
        rd_addr  = {beam_nxt, ch_nxt};
        wr_addr  = {wr_beam, wr_ch};
    end

    // Table has no reset; a read and write to one address in a cycle returns the old entry.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= {wr_imag, wr_real};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ch_cnt   <= '0;
            gap_cnt  <= '0;
            beam_act <= '0;
        end else begin
            if (state == IDLE || in_valid)
                gap_cnt <= '0;
            else if (!timeout)
                gap_cnt <= gap_cnt + 8'd1;

            if (timeout) begin
                state  <= IDLE;
                ch_cnt <= '0;
            end else if (emit) begin
                state  <= last ? IDLE : RUN;
                ch_cnt <= last ? '0 : ch_nxt + CW'(1);
            end

            if (sof_hit)
                beam_act <= beam_sel;
        end
    end

    // Data and weight outputs only move on an emitted sample so they hold across gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_in_valid <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            dataI         <= '0;
            dataQ         <= '0;
            ph_real       <= '0;
            ph_image      <= '0;
            ch_idx        <= '0;
        end else begin
            data_in_valid <= emit;
            frame_done    <= last;
            frame_err     <= resync | timeout;
            if (emit) begin
                dataI               <= in_I;
                dataQ               <= in_Q;
                ch_idx              <= ch_nxt;
                {ph_image, ph_real} <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_dbf_weight_sched.sv
// Directed bench for dbf_weight_sched: weight pairing, frame sequencing, resync,
// read-first table collision, idle drop, gap timeout and async reset.
module tb_dbf_weight_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_beam;
    logic [2:0]  wr_ch;
    logic [15:0] wr_real, wr_imag;
    logic [1:0]  beam_sel;
    logic        in_valid, in_sof;
    logic [15:0] in_I, in_Q;
    logic        data_in_valid;
    logic [15:0] dataI, dataQ, ph_real, ph_image;
    logic [2:0]  ch_idx;
    logic [1:0]  beam_act;
    logic        frame_done, frame_err;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_re [4][8];
    logic [15:0] exp_im [4][8];
    int          wr_at_ch = -1;
    logic [15:0] ov_re, ov_im;
    int          vcnt;

    dbf_weight_sched #(.N_CH(8), .N_BEAM(4), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_beam(wr_beam), .wr_ch(wr_ch), .wr_real(wr_real), .wr_imag(wr_imag),
        .beam_sel(beam_sel), .in_valid(in_valid), .in_sof(in_sof), .in_I(in_I), .in_Q(in_Q),
        .data_in_valid(data_in_valid), .dataI(dataI), .dataQ(dataQ),
        .ph_real(ph_real), .ph_image(ph_image), .ch_idx(ch_idx), .beam_act(beam_act),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // One full frame on beam b; beam_sel is scrambled off the sof to prove it is ignored.
    task automatic send_frame(input logic [1:0] b, input logic [15:0] base);
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_sof   = (c == 0);
            beam_sel = (c == 0) ? b : ~b;
            in_I     = base + 16'(c);
            in_Q     = 16'h0100 + 16'(c);
            if (c == wr_at_ch) begin
                wr_en = 1'b1; wr_beam = b; wr_ch = 3'(c); wr_real = ov_re; wr_imag = ov_im;
            end
            step();
            wr_en = 1'b0;
            chk("valid", data_in_valid, 1);
            chk("dataI", dataI, base + 16'(c));
            chk("dataQ", dataQ, 16'h0100 + 16'(c));
            chk("ch_idx", ch_idx, c);
            chk("beam_act", beam_act, b);
            chk("ph_real", ph_real, exp_re[b][c]);
            chk("ph_image", ph_image, exp_im[b][c]);
            chk("frame_done", frame_done, c == 7);
            chk("frame_err", frame_err, 0);
            if (c == wr_at_ch) begin
                exp_re[b][c] = ov_re;
                exp_im[b][c] = ov_im;
            end
        end
        wr_at_ch = -1;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_beam = '0; wr_ch = '0; wr_real = '0; wr_imag = '0;
        beam_sel = '0; in_I = '0; in_Q = '0;
        idle_in();
        step(); step();
        chk("rst_valid", data_in_valid, 0);
        chk("rst_dataI", dataI, 0);
        chk("rst_ph_real", ph_real, 0);
        chk("rst_ph_image", ph_image, 0);
        chk("rst_ch_idx", ch_idx, 0);
        chk("rst_beam_act", beam_act, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", frame_err, 0);
        rst_n = 1'b1;
        step();

        // Load w[b][c] = {-(b*16+c), b*16+c}
        for (int b = 0; b < 4; b++)
            for (int c = 0; c < 8; c++) begin
                wr_en   = 1'b1;
                wr_beam = 2'(b);
                wr_ch   = 3'(c);
                wr_real = 16'(b * 16 + c);
                wr_imag = 16'(-(b * 16 + c));
                exp_re[b][c] = 16'(b * 16 + c);
                exp_im[b][c] = 16'(-(b * 16 + c));
                step();
            end
        wr_en = 1'b0;
        step();

        // Two frames on beam 2; output only appears one edge after the sample
        in_valid = 1'b1; in_sof = 1'b1; beam_sel = 2'd2;
        chk("lat_pre_edge", data_in_valid, 0);
        send_frame(2'd2, 16'd0);
        send_frame(2'd2, 16'd0);
        idle_in();
        step();
        chk("gap_valid", data_in_valid, 0);
        chk("hold_dataI", dataI, 7);
        chk("hold_ph_real", ph_real, 16'd39);
        chk("done_clear", frame_done, 0);

        // Back-to-back beams 1 then 3, no bubble
        vcnt = 0;
        fork
            begin
                send_frame(2'd1, 16'd20);
                send_frame(2'd3, 16'd40);
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    @(posedge clk); #2;
                    if (data_in_valid) vcnt++;
                end
            end
        join
        chk("b2b_valid_count", vcnt, 16);
        idle_in();
        step();

        // Resync: sof after ch3
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_sof = (c == 0); beam_sel = 2'd0; in_I = 16'(c);
            step();
        end
        in_valid = 1'b1; in_sof = 1'b1; beam_sel = 2'd1; in_I = 16'h00aa;
        step();
        chk("resync_err", frame_err, 1);
        chk("resync_ch", ch_idx, 0);
        chk("resync_done", frame_done, 0);
        chk("resync_beam", beam_act, 1);
        chk("resync_ph", ph_real, 16'd16);
        for (int c = 1; c < 8; c++) begin
            in_sof = 1'b0; in_I = 16'(c);
            step();
            chk("post_resync_err", frame_err, 0);
            chk("post_resync_ch", ch_idx, c);
        end
        chk("post_resync_done", frame_done, 1);
        idle_in();
        step();

        // Read-first collision on w[0][5]
        wr_at_ch = 5; ov_re = 16'h1234; ov_im = 16'h4321;
        send_frame(2'd0, 16'd0);
        send_frame(2'd0, 16'd0);
        chk("new_w05_real", exp_re[0][5], 16'h1234);
        idle_in();
        step();

        // Valid without sof while idle is dropped
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sof = 1'b0; in_I = 16'h0bad;
            step();
            chk("idle_drop", data_in_valid, 0);
        end
        // Short gap keeps the frame alive
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_sof = (c == 0); beam_sel = 2'd3; in_I = 16'(c);
            step();
        end
        idle_in();
        for (int i = 0; i < 10; i++) step();
        chk("gap10_err", frame_err, 0);
        in_valid = 1'b1; in_I = 16'd3;
        step();
        chk("gap10_cont_ch", ch_idx, 3);
        chk("gap10_cont_v", data_in_valid, 1);
        // Long gap times out on the 256th empty cycle
        idle_in();
        vcnt = 0;
        for (int i = 1; i <= 300 && vcnt == 0; i++) begin
            step();
            if (frame_err) vcnt = i;
        end
        chk("timeout_cycle", vcnt, 256);
        step();
        chk("timeout_pulse", frame_err, 0);
        in_valid = 1'b1; in_sof = 1'b0; in_I = 16'd4;
        step();
        chk("timeout_idle_drop", data_in_valid, 0);
        idle_in();
        step();

        // Async reset mid-frame
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_sof = (c == 0); beam_sel = 2'd3; in_I = 16'(c + 1);
            step();
        end
        chk("pre_rst_ch", ch_idx, 4);
        rst_n = 1'b0;
        #1;
        chk("async_valid", data_in_valid, 0);
        chk("async_dataI", dataI, 0);
        chk("async_ph", ph_real, 0);
        chk("async_ch", ch_idx, 0);
        chk("async_beam", beam_act, 0);
        #2 rst_n = 1'b1;
        in_valid = 1'b1; in_sof = 1'b0; in_I = 16'd6;
        step();
        chk("post_rst_drop", data_in_valid, 0);
        in_sof = 1'b1; beam_sel = 2'd2; in_I = 16'h0077;
        step();
        chk("post_rst_valid", data_in_valid, 1);
        chk("post_rst_ch", ch_idx, 0);
        chk("post_rst_beam", beam_act, 2);
        chk("post_rst_dataI", dataI, 16'h0077);
        idle_in();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
